button_debouncer: RTL and testbench
===================================

// Module: button_debouncer
// PURPOSE
//   Conditions raw, asynchronous, bouncing push-button inputs (board buttons for cursor
//   move / place on the VGA tic-tac-toe board) into clean, glitch-free levels.
//   Sits directly upstream of the rising-edge pulse stage: btn_clean[i] drives that
//   stage's input, which turns each accepted press into a one-cycle move/place pulse.
//   Also flags long presses (btn_held) for auto-repeat / board-reset use by game control.
// PARAMETERS
//   N_BTN            5          number of independent button channels (>=1)
//   DEBOUNCE_CYCLES  1000000    cycles a new level must stay stable before acceptance (>=2; 10 ms @ 100 MHz)
//   HOLD_CYCLES      50000000   cycles in accepted-high state before btn_held asserts (>=1; 0.5 s @ 100 MHz)
//   Counter widths derived internally via $clog2; no overflow for any legal value
// PORTS
//   clk        in   1      system clock
//   rst        in   1      synchronous, active-high reset
//   btn_raw    in   N_BTN  raw button levels, asynchronous to clk, active-high
//   btn_clean  out  N_BTN  debounced level per channel (registered)
//   btn_held   out  N_BTN  long-press flag per channel (registered)
//   unstable   out  1      OR over channels of "in WAIT_HIGH or WAIT_LOW" (registered)
// BEHAVIOUR
//   Reset: sync flops, FSMs -> LOW, counters, btn_clean, btn_held, unstable all 0.
//   Per channel, fully independent; no cross-channel interaction.
//   Synchronizer: 2-flop chain per bit; sync = second flop. Raw change sampled at edge k
//     is visible to FSM as sync at edge k+1, acted on at edge k+2.
//   FSM states / transitions (one counter per channel, dbc):
//     LOW       clean=0. sync=1 -> WAIT_HIGH, dbc<=0.
//     WAIT_HIGH clean=0. sync=0 -> LOW (bounce, count discarded).
//               sync=1 & dbc<DEBOUNCE_CYCLES-1 -> dbc++.
//               sync=1 & dbc==DEBOUNCE_CYCLES-1 -> HIGH, clean<=1.
//     HIGH      clean=1. sync=0 -> WAIT_LOW, dbc<=0.
//     WAIT_LOW  clean=1. sync=1 -> HIGH (bounce, count discarded).
//               sync=0 & dbc<DEBOUNCE_CYCLES-1 -> dbc++.
//               sync=0 & dbc==DEBOUNCE_CYCLES-1 -> LOW, clean<=0.
//   Latency: clean raw step sampled at edge k -> btn_clean toggles at edge k+2+DEBOUNCE_CYCLES.
//   Any opposing sync sample during WAIT_* returns to prior stable state; btn_clean never glitches.
//   Hold counter hc: cleared whenever state != HIGH and != WAIT_LOW; increments in HIGH,
//     saturates at HOLD_CYCLES; btn_held<=1 on edge hc reaches HOLD_CYCLES.
//     Held in WAIT_LOW (bounce on release does not drop it); btn_held<=0 on same edge
//     btn_clean<=0.
//   unstable asserts from the edge a channel enters WAIT_* until edge it leaves.
//   Reset mid-debounce or mid-hold: everything returns to reset values next edge;
//     raw level already high at reset release needs full 2+DEBOUNCE_CYCLES to be accepted.
//   Simultaneous presses on several channels: each debounced independently, same latency.
// TESTING (bench uses DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, N_BTN=5)
//   1 Reset: rst=1 with btn_raw=5'b11111 -> all outputs 0; release rst -> btn_clean=5'b11111
//     exactly 6 cycles later.
//   2 Clean press ch0: raw 0->1 at edge k -> btn_clean[0]=1 at k+6, unstable=1 on k+2..k+5 only.
//   3 Bounce: raw ch2 high 3 cycles, low 1, high 3 -> btn_clean[2] stays 0, returns to LOW;
//     held high 6+ cycles -> accepts.
//   4 Release bounce: ch1 accepted high, raw low 2 cycles then high -> btn_clean[1] stays 1,
//     btn_held unaffected.
//   5 Long press ch4: held high -> btn_held[4]=1 exactly 8 cycles after btn_clean[4]=1;
//     release -> both drop on same edge, 6 cycles after raw falls.
//   6 Reset mid-WAIT_HIGH on ch3 (dbc=2) -> outputs 0 next edge, full 6-cycle latency
//     afterwards; other channels unaffected by ch3 activity.

Source files
------------

// File: rtl/button_debouncer.sv
// Per-channel push-button conditioner: 2-flop synchronizer, debounce FSM with stability counter,
// and a long-press detector that survives release bounce.
module button_debouncer #(
  parameter int unsigned N_BTN           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw_i,
  output logic [N_BTN-1:0] btn_clean_o,
  output logic [N_BTN-1:0] btn_held_o,
  output logic             unstable_o
);

  localparam int unsigned DbcW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HcW  = $clog2(HOLD_CYCLES + 1);
  localparam logic [DbcW-1:0] DbcLast = DbcW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HcW-1:0]  HcMax   = HcW'(HOLD_CYCLES);

  typedef enum logic [1:0] {StLow, StWaitHigh, StHigh, StWaitLow} state_e;

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [N_BTN-1:0] wait_d;
  logic             unstable_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    state_e          state_q, state_d;
    logic [DbcW-1:0] dbc_q, dbc_d;
    logic [HcW-1:0]  hc_q, hc_d;
    logic            clean_q, clean_d;
    logic            held_q, held_d;
    logic            sync;

    assign sync = sync2_q[i];

    always_comb begin
      state_d = state_q;
      dbc_d   = dbc_q;
      hc_d    = hc_q;
      clean_d = clean_q;
      held_d  = held_q;

      unique case (state_q)
        StLow: begin
          if (sync) begin
            state_d = StWaitHigh;
            dbc_d   = '0;
          end
        end
        StWaitHigh: begin
          if (!sync) begin
            state_d = StLow;
          end else if (dbc_q == DbcLast) begin
            state_d = StHigh;
            clean_d = 1'b1;
          end else begin
            dbc_d = dbc_q + DbcW'(1);
          end
        end
        StHigh: begin
          if (!sync) begin
            state_d = StWaitLow;
            dbc_d   = '0;
          end
        end
        StWaitLow: begin
          if (sync) begin
            state_d = StHigh;
          end else if (dbc_q == DbcLast) begin
            state_d = StLow;
            clean_d = 1'b0;
            held_d  = 1'b0;
          end else begin
            dbc_d = dbc_q + DbcW'(1);
          end
        end
      endcase

      // Hold count freezes during release bounce so a bounce never restarts a long press.
      if (state_q == StHigh) begin
        if (hc_q != HcMax) begin
          hc_d = hc_q + HcW'(1);
          if (hc_q == HcMax - HcW'(1)) begin
            held_d = 1'b1;
          end
        end
      end else if (state_q != StWaitLow) begin
        hc_d = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= StLow;
        dbc_q   <= '0;
        hc_q    <= '0;
        clean_q <= 1'b0;
        held_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        dbc_q   <= dbc_d;
        hc_q    <= hc_d;
        clean_q <= clean_d;
        held_q  <= held_d;
      end
    end

    assign wait_d[i]      = (state_d == StWaitHigh) || (state_d == StWaitLow);
    assign btn_clean_o[i] = clean_q;
    assign btn_held_o[i]  = held_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      unstable_q <= 1'b0;
    end else begin
      unstable_q <= |wait_d;
    end
  end

  assign unstable_o = unstable_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: expectations are queued with their due cycle when stimulus
// is driven and checked on the falling edge of that cycle.
module tb_button_debouncer;

  localparam int Limit = 2000;

  typedef struct {
    int         at;
    logic [4:0] cmask;
    logic [4:0] clean;
    logic [4:0] hmask;
    logic [4:0] held;
    bit         uchk;
    logic       unst;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] raw;
  logic [4:0] clean;
  logic [4:0] held;
  logic       unst;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   c, d, r;
  exp_t q[$];
  exp_t cur;

  button_debouncer #(
    .N_BTN          (5),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw_i  (raw),
    .btn_clean_o(clean),
    .btn_held_o (held),
    .unstable_o (unst)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int at, input logic [4:0] cm, input logic [4:0] cv,
                      input logic [4:0] hm, input logic [4:0] hv, input bit uc,
                      input logic uv, input string tag);
    exp_t e;
    int   i;
    e.at = at; e.cmask = cm; e.clean = cv & cm; e.hmask = hm; e.held = hv & hm;
    e.uchk = uc; e.unst = uv; e.tag = tag;
    i = 0;
    while (i < q.size() && q[i].at <= at) i++;
    q.insert(i, e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    while (q.size() != 0 && q[0].at <= cyc) begin
      cur = q.pop_front();
      checks++;
      assert (cur.at == cyc) else begin
        errors++; $error("FAIL %s timing: checked at %0d, due %0d", cur.tag, cyc, cur.at);
      end
      if (cur.cmask != 5'b0) begin
        checks++;
        assert ((clean & cur.cmask) === cur.clean) else begin
          errors++;
          $error("FAIL %s btn_clean: got %b want %b (mask %b)", cur.tag, clean & cur.cmask,
                 cur.clean, cur.cmask);
        end
      end
      if (cur.hmask != 5'b0) begin
        checks++;
        assert ((held & cur.hmask) === cur.held) else begin
          errors++;
          $error("FAIL %s btn_held: got %b want %b (mask %b)", cur.tag, held & cur.hmask,
                 cur.held, cur.hmask);
        end
      end
      if (cur.uchk) begin
        checks++;
        assert (unst === cur.unst) else begin
          errors++; $error("FAIL %s unstable: got %b want %b", cur.tag, unst, cur.unst);
        end
      end
    end
    if (cyc == Limit) begin
      checks++;
      assert (q.size() == 0) else begin
        errors++; $error("FAIL drain: %0d expectations pending, want 0", q.size());
      end
    end
  end

  initial begin
    rst = 1'b1;
    raw = 5'b11111;

    // 1: reset holds everything low even with all buttons pressed
    @(negedge clk);
    c = cyc;
    push(c + 1, 5'b11111, 5'b0, 5'b11111, 5'b0, 1, 1'b0, "t1_reset_a");
    push(c + 2, 5'b11111, 5'b0, 5'b11111, 5'b0, 1, 1'b0, "t1_reset_b");
    tick(2);
    c = cyc;
    rst = 1'b0;
    push(c + 3, 5'b0, 5'b0, 5'b0, 5'b0, 1, 1'b1, "t1_unst_on");
    push(c + 6, 5'b11111, 5'b0, 5'b11111, 5'b0, 1, 1'b1, "t1_pre");
    push(c + 7, 5'b11111, 5'b11111, 5'b11111, 5'b0, 1, 1'b0, "t1_accept");
    push(c + 14, 5'b0, 5'b0, 5'b11111, 5'b0, 0, 1'b0, "t1_held_pre");
    push(c + 15, 5'b0, 5'b0, 5'b11111, 5'b11111, 0, 1'b0, "t1_held");
    tick(20);
    c = cyc;
    raw = 5'b0;
    push(c + 6, 5'b11111, 5'b11111, 5'b11111, 5'b11111, 1, 1'b1, "t1_rel_pre");
    push(c + 7, 5'b11111, 5'b0, 5'b11111, 5'b0, 1, 1'b0, "t1_rel");
    tick(10);

    // 2: clean press on ch0, unstable window exactly four cycles
    c = cyc;
    raw[0] = 1'b1;
    push(c + 2, 5'b0, 5'b0, 5'b0, 5'b0, 1, 1'b0, "t2_unst_pre");
    for (int i = 3; i <= 6; i++) push(c + i, 5'b0, 5'b0, 5'b0, 5'b0, 1, 1'b1, "t2_unst");
    push(c + 6, 5'b00001, 5'b0, 5'b0, 5'b0, 0, 1'b0, "t2_pre");
    push(c + 7, 5'b00001, 5'b00001, 5'b0, 5'b0, 1, 1'b0, "t2_accept");
    tick(10);

    // 3: bouncing press on ch2 is rejected, then a steady press is accepted
    c = cyc;
    raw[2] = 1'b1;
    for (int i = 3; i <= 12; i++) push(c + i, 5'b00100, 5'b0, 5'b0, 5'b0, 0, 1'b0, "t3_bounce");
    push(c + 5, 5'b0, 5'b0, 5'b0, 5'b0, 1, 1'b1, "t3_wait_a");
    push(c + 6, 5'b0, 5'b0, 5'b0, 5'b0, 1, 1'b0, "t3_back_low_a");
    push(c + 7, 5'b0, 5'b0, 5'b0, 5'b0, 1, 1'b1, "t3_wait_b");
    push(c + 10, 5'b0, 5'b0, 5'b0, 5'b0, 1, 1'b0, "t3_back_low_b");
    tick(3);
    raw[2] = 1'b0;
    tick(1);
    raw[2] = 1'b1;
    tick(3);
    raw[2] = 1'b0;
    tick(5);
    c = cyc;
    raw[2] = 1'b1;
    push(c + 6, 5'b00100, 5'b0, 5'b0, 5'b0, 0, 1'b0, "t3_steady_pre");
    push(c + 7, 5'b00100, 5'b00100, 5'b0, 5'b0, 0, 1'b0, "t3_steady");
    tick(10);

    // 4: release bounce on ch1 keeps it high; hold count pauses for the bounce
    c = cyc;
    raw[1] = 1'b1;
    push(c + 7, 5'b00010, 5'b00010, 5'b00010, 5'b0, 0, 1'b0, "t4_accept");
    push(c + 16, 5'b0, 5'b0, 5'b00010, 5'b0, 0, 1'b0, "t4_held_pre");
    push(c + 17, 5'b0, 5'b0, 5'b00010, 5'b00010, 0, 1'b0, "t4_held");
    tick(10);
    d = cyc;
    raw[1] = 1'b0;
    for (int i = 1; i <= 8; i++) push(d + i, 5'b00010, 5'b00010, 5'b0, 5'b0, 0, 1'b0, "t4_keep");
    tick(2);
    raw[1] = 1'b1;
    tick(12);

    // 5: long press on ch4, then release drops clean and held together
    c = cyc;
    raw[4] = 1'b1;
    push(c + 6, 5'b10000, 5'b0, 5'b10000, 5'b0, 0, 1'b0, "t5_pre");
    push(c + 7, 5'b10000, 5'b10000, 5'b10000, 5'b0, 0, 1'b0, "t5_accept");
    push(c + 14, 5'b0, 5'b0, 5'b10000, 5'b0, 0, 1'b0, "t5_held_pre");
    push(c + 15, 5'b0, 5'b0, 5'b10000, 5'b10000, 0, 1'b0, "t5_held");
    tick(20);
    r = cyc;
    raw[4] = 1'b0;
    push(r + 6, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 0, 1'b0, "t5_rel_pre");
    push(r + 7, 5'b10000, 5'b0, 5'b10000, 5'b0, 0, 1'b0, "t5_rel");
    tick(10);

    // 6: reset while ch3 is mid-debounce; other channels untouched until the reset
    c = cyc;
    raw[3] = 1'b1;
    for (int i = 1; i <= 5; i++)
      push(c + i, 5'b00111, 5'b00111, 5'b00111, 5'b00111, 0, 1'b0, "t6_others");
    push(c + 5, 5'b01000, 5'b0, 5'b0, 5'b0, 1, 1'b1, "t6_ch3_wait");
    tick(5);
    rst = 1'b1;
    push(c + 6, 5'b11111, 5'b0, 5'b11111, 5'b0, 1, 1'b0, "t6_reset");
    tick(1);
    r = cyc;
    rst = 1'b0;
    push(r + 3, 5'b0, 5'b0, 5'b0, 5'b0, 1, 1'b1, "t6_unst_on");
    push(r + 6, 5'b11111, 5'b0, 5'b11111, 5'b0, 1, 1'b1, "t6_pre");
    push(r + 7, 5'b11111, 5'b01111, 5'b11111, 5'b0, 1, 1'b0, "t6_accept");
    push(r + 14, 5'b0, 5'b0, 5'b11111, 5'b0, 0, 1'b0, "t6_held_pre");
    push(r + 15, 5'b0, 5'b0, 5'b11111, 5'b01111, 0, 1'b0, "t6_held");

    while (q.size() != 0 && cyc <= Limit) @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
